// File: rtl/clock_pkg.sv
// Shared definitions for the clock/timer designs: FSM encoding, display blank and BCD limits.
package clock_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPause   = 2'd2,
    StExpired = 2'd3
  } state_e;

  localparam logic [6:0] BLANK        = 7'h7f;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;
  localparam logic [3:0] BCD_ONES_MAX = 4'd9;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } bcd_time_t;

  // Two-digit BCD increment over 00..59, wrapping 59 to 00.
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones == BCD_ONES_MAX) begin
      ones = 4'd0;
      tens = (tens == BCD_TENS_MAX) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/hex_7seg.sv
// BCD digit to active-low 7-segment decoder; non-decimal codes show blank.
module hex_7seg
  import clock_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_digit)
      4'd0:    o_seg = 7'h40;
      4'd1:    o_seg = 7'h79;
      4'd2:    o_seg = 7'h24;
      4'd3:    o_seg = 7'h30;
      4'd4:    o_seg = 7'h19;
      4'd5:    o_seg = 7'h12;
      4'd6:    o_seg = 7'h02;
      4'd7:    o_seg = 7'h78;
      4'd8:    o_seg = 7'h00;
      4'd9:    o_seg = 7'h10;
      default: o_seg = BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with set/start/pause keys, expiry flag and 1 Hz alarm blink.
module countdown_timer
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       dakika_ayar,
  input  logic       saniye_ayar,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [6:0] HEX6,
  output logic [6:0] HEX7,
  output logic       done,
  output logic       alarm
);

  localparam int unsigned HALF = TICKS_PER_SEC / 2;
  localparam int unsigned PW   = $clog2(TICKS_PER_SEC);
  localparam int unsigned AW   = $clog2(HALF);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [AW-1:0] ALARM_MAX = AW'(HALF - 1);

  // Key order in the vectors below: {start, minute, second}.
  logic [2:0] w_keys;
  logic [2:0] r_sync1, r_sync2, r_prev, r_press;
  logic       w_start, w_min, w_sec;

  assign w_keys  = {start_stop, dakika_ayar, saniye_ayar};
  assign w_start = r_press[2];
  assign w_min   = r_press[1];
  assign w_sec   = r_press[0];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_press <= '0;
    end else begin
      r_sync1 <= w_keys;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_press <= r_prev & ~r_sync2;
    end
  end

  state_e    r_state;
  bcd_time_t r_time, w_dec;
  logic [PW-1:0] r_presc;
  logic [AW-1:0] r_acnt;
  logic r_done, r_alarm;

  // One-second BCD decrement; only applied while the time is non-zero.
  always_comb begin
    w_dec = r_time;
    if (r_time.sec_o != 4'd0) begin
      w_dec.sec_o = r_time.sec_o - 4'd1;
    end else begin
      w_dec.sec_o = BCD_ONES_MAX;
      if (r_time.sec_t != 4'd0) begin
        w_dec.sec_t = r_time.sec_t - 4'd1;
      end else begin
        w_dec.sec_t = BCD_TENS_MAX;
        if (r_time.min_o != 4'd0) begin
          w_dec.min_o = r_time.min_o - 4'd1;
        end else begin
          w_dec.min_o = BCD_ONES_MAX;
          w_dec.min_t = r_time.min_t - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_time  <= '0;
      r_presc <= '0;
      r_acnt  <= '0;
      r_done  <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            if (r_time != '0) begin
              r_state <= StRun;
              r_presc <= '0;
            end
          end else if (w_min) begin
            {r_time.min_t, r_time.min_o} <= bcd_inc60({r_time.min_t, r_time.min_o});
          end else if (w_sec) begin
            {r_time.sec_t, r_time.sec_o} <= bcd_inc60({r_time.sec_t, r_time.sec_o});
          end
        end
        StRun: begin
          if (w_start) begin
            r_state <= StPause;
          end else if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
            r_time  <= w_dec;
            if (w_dec == '0) begin
              r_state <= StExpired;
              r_done  <= 1'b1;
              r_alarm <= 1'b1;
              r_acnt  <= '0;
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        StPause: begin
          if (w_start) begin
            r_state <= StRun;
          end else if (w_min) begin
            r_state <= StIdle;
          end
        end
        StExpired: begin
          if (|r_press) begin
            r_state <= StIdle;
            r_time  <= '0;
            r_done  <= 1'b0;
            r_alarm <= 1'b0;
            r_acnt  <= '0;
          end else if (r_acnt == ALARM_MAX) begin
            r_acnt  <= '0;
            r_alarm <= ~r_alarm;
          end else begin
            r_acnt <= r_acnt + AW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign done  = r_done;
  assign alarm = r_alarm;
  assign HEX0  = BLANK;
  assign HEX1  = BLANK;
  assign HEX6  = BLANK;
  assign HEX7  = BLANK;

  hex_7seg u_sec_o (.i_digit(r_time.sec_o), .o_seg(HEX2));
  hex_7seg u_sec_t (.i_digit(r_time.sec_t), .o_seg(HEX3));
  hex_7seg u_min_o (.i_digit(r_time.min_o), .o_seg(HEX4));
  hex_7seg u_min_t (.i_digit(r_time.min_t), .o_seg(HEX5));

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: seconds-based reference model, per-cycle compare, directed and random keys.
module tb_countdown_timer;

  localparam int TPS = 10;
  localparam int MIdle = 0, MRun = 1, MPause = 2, MExp = 3;

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic k_start = 1'b1, k_min = 1'b1, k_sec = 1'b1;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic done, alarm;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start_stop(k_start), .dakika_ayar(k_min),
    .saniye_ayar(k_sec), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4),
    .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7), .done(done), .alarm(alarm)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
      default: return 7'h7f;
    endcase
  endfunction

  function automatic logic [27:0] disp_of(input int mm, input int ss);
    return {seg(mm / 10), seg(mm % 10), seg(ss / 10), seg(ss % 10)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: time held as total seconds, keys as a history of sampled levels.
  int m_state = MIdle, m_t = 0, m_presc = 0, m_ecyc = 0;
  bit [2:0] h1 = '1, h2 = '1, h3 = '1, h4 = '1;

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m_state = MIdle; m_t = 0; m_presc = 0; m_ecyc = 0;
      h1 = '1; h2 = '1; h3 = '1; h4 = '1;
    end else begin
      bit [2:0] pr;
      int mm, ss;
      pr = h4 & ~h3;
      h4 = h3; h3 = h2; h2 = h1; h1 = {k_start, k_min, k_sec};
      mm = m_t / 60;
      ss = m_t % 60;
      case (m_state)
        MIdle: begin
          if (pr[2]) begin
            if (m_t != 0) begin m_state = MRun; m_presc = 0; end
          end else if (pr[1]) m_t = ((mm + 1) % 60) * 60 + ss;
          else if (pr[0]) m_t = mm * 60 + (ss + 1) % 60;
        end
        MRun: begin
          if (pr[2]) m_state = MPause;
          else begin
            m_presc++;
            if (m_presc == TPS) begin
              m_presc = 0;
              m_t--;
              if (m_t == 0) begin m_state = MExp; m_ecyc = 0; end
            end
          end
        end
        MPause: begin
          if (pr[2]) m_state = MRun;
          else if (pr[1]) m_state = MIdle;
        end
        default: begin
          if (pr != 0) begin m_state = MIdle; m_t = 0; end
          else m_ecyc++;
        end
      endcase
    end
  end

  function automatic logic [63:0] model_out();
    logic m_done, m_alarm;
    m_done  = (m_state == MExp);
    m_alarm = m_done && ((m_ecyc / (TPS / 2)) % 2 == 0);
    return {6'd0, 7'h7f, 7'h7f, disp_of(m_t / 60, m_t % 60), 7'h7f, 7'h7f, m_done, m_alarm};
  endfunction

  always @(negedge CLOCK_50) begin
    if (chk_en)
      check("cycle", {6'd0, HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, done, alarm},
            model_out());
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic press(input bit s, input bit m, input bit sc);
    @(negedge CLOCK_50);
    k_start = ~s; k_min = ~m; k_sec = ~sc;
    tick(2);
    k_start = 1'b1; k_min = 1'b1; k_sec = 1'b1;
    tick(4);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    #2 reset = 1'b1;
    tick(2);
    #2 reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_disp(input string name, input logic [27:0] target, input int budget,
                           output int cyc);
    cyc = 0;
    while ({HEX5, HEX4, HEX3, HEX2} !== target && cyc < budget) begin
      tick(1);
      cyc++;
    end
    check(name, {36'd0, HEX5, HEX4, HEX3, HEX2}, {36'd0, target});
  endtask

  initial begin
    int c;
    tick(3);
    check("reset_disp", {8'd0, HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0},
          {8'd0, 7'h7f, 7'h7f, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7f, 7'h7f});
    check("reset_flags", {62'd0, done, alarm}, 64'd0);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    tick(2);

    // 3 minute presses, 5 second presses
    repeat (3) press(0, 1, 0);
    repeat (5) press(0, 0, 1);
    check("set_0305", {36'd0, HEX5, HEX4, HEX3, HEX2}, {36'd0, 7'h40, 7'h30, 7'h40, 7'h12});
    tick(30);
    check("idle_hold", {36'd0, HEX5, HEX4, HEX3, HEX2}, {36'd0, 7'h40, 7'h30, 7'h40, 7'h12});

    // 00:02 countdown to expiry and alarm blink
    do_reset();
    repeat (2) press(0, 0, 1);
    press(1, 0, 0);
    wait_disp("run_01", {7'h40, 7'h40, 7'h40, 7'h79}, 20, c);
    wait_disp("run_00", {7'h40, 7'h40, 7'h40, 7'h40}, 15, c);
    check("sec_period", 64'(c), 64'd10);
    check("done_on_zero", {62'd0, done, alarm}, 64'd3);
    c = 0;
    while (alarm === 1'b1 && c < 20) begin tick(1); c++; end
    check("alarm_high_len", 64'(c), 64'd5);
    c = 0;
    while (alarm === 1'b0 && c < 20) begin tick(1); c++; end
    check("alarm_low_len", 64'(c), 64'd5);
    press(0, 0, 1);
    check("exp_clear", {34'd0, HEX5, HEX4, HEX3, HEX2, done, alarm},
          {34'd0, 7'h40, 7'h40, 7'h40, 7'h40, 2'b00});

    // 01:00 run, pause, resume
    press(0, 1, 0);
    press(1, 0, 0);
    wait_disp("to_0059", {7'h40, 7'h40, 7'h12, 7'h10}, 20, c);
    press(1, 0, 0);
    tick(50);
    check("pause_hold", {36'd0, HEX5, HEX4, HEX3, HEX2}, {36'd0, 7'h40, 7'h40, 7'h12, 7'h10});
    press(1, 0, 0);
    wait_disp("to_0058", {7'h40, 7'h40, 7'h12, 7'h00}, 15, c);
    press(1, 0, 0);
    press(0, 1, 0);
    tick(20);
    check("pause_to_idle", {36'd0, HEX5, HEX4, HEX3, HEX2}, {36'd0, 7'h40, 7'h40, 7'h12, 7'h00});

    // start ignored at 00:00; 60 second presses wrap
    do_reset();
    press(1, 0, 0);
    tick(20);
    check("zero_start", {34'd0, HEX5, HEX4, HEX3, HEX2, done, alarm},
          {34'd0, 7'h40, 7'h40, 7'h40, 7'h40, 2'b00});
    repeat (60) press(0, 0, 1);
    check("sec_wrap", {36'd0, HEX5, HEX4, HEX3, HEX2}, {36'd0, 7'h40, 7'h40, 7'h40, 7'h40});

    // start + minute together at 00:10
    repeat (10) press(0, 0, 1);
    press(1, 1, 0);
    check("prio_min", {50'd0, HEX5, HEX4}, {50'd0, 7'h40, 7'h40});
    wait_disp("prio_run", {7'h40, 7'h40, 7'h40, 7'h10}, 15, c);

    // reset mid-run at 00:07
    wait_disp("to_0007", {7'h40, 7'h40, 7'h40, 7'h78}, 40, c);
    #3 reset = 1'b1;
    #1;
    check("async_reset", {34'd0, HEX5, HEX4, HEX3, HEX2, done, alarm},
          {34'd0, 7'h40, 7'h40, 7'h40, 7'h40, 2'b00});
    tick(2);
    #2 reset = 1'b0;
    tick(30);
    check("post_reset", {34'd0, HEX5, HEX4, HEX3, HEX2, done, alarm},
          {34'd0, 7'h40, 7'h40, 7'h40, 7'h40, 2'b00});

    // random keys with occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLOCK_50);
      #2;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) reset = 1'b1;
      k_start = ($urandom_range(0, 59) != 0);
      k_min   = ($urandom_range(0, 199) != 0);
      k_sec   = ($urandom_range(0, 24) != 0);
    end
    @(negedge CLOCK_50);
    #2 reset = 1'b0;
    k_start = 1'b1; k_min = 1'b1; k_sec = 1'b1;
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50_000_000, meaning CLOCK_50 cycles per second; must be even and >= 4.
REQ-002 SHALL have port CLOCK_50  input  1  the single clock for all logic.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_stop  input  1  active-low push key that starts, pauses or resumes counting.
REQ-005 SHALL have port dakika_ayar  input  1  active-low minute-set key.
REQ-006 SHALL have port saniye_ayar  input  1  active-low second-set key.
REQ-007 SHALL have ports HEX0..HEX7  output  7 each  active-low 7-segment digits.
- HEX2/HEX3: seconds ones/tens.
- HEX4/HEX5: minutes ones/tens.
- HEX0, HEX1, HEX6, HEX7: constant BLANK 7'h7f.
REQ-008 SHALL have port done  output  1  high while the timer is in EXPIRED.
REQ-009 SHALL have port alarm  output  1  1 Hz blink while in EXPIRED, else 0.

Function
REQ-010 SHALL pass each key through a 2-flop synchronizer, then a falling-edge detector, giving a 1-cycle press pulse.
- Latency from pin to pulse: 3 cycles.
- No debounce; keys are assumed clean.
REQ-011 SHALL hold time as four BCD digits: min tens 0-5, min ones 0-9, sec tens 0-5, sec ones 0-9.
REQ-012 SHALL implement states IDLE, RUN, PAUSE, EXPIRED.
REQ-013 IDLE behaviour:
- minute press: minutes +1, 59 wraps to 00, seconds unchanged, no carry.
- second press: seconds +1, 59 wraps to 00, no carry into minutes.
- start press with time != 00:00: go to RUN with prescaler cleared to 0.
- start press with time == 00:00: ignored.
REQ-014 RUN behaviour:
- prescaler counts 0..TICKS_PER_SEC-1 and wraps.
- on wrap, time decrements by one second: sec ones 0->9 with sec tens -1; sec 00->59 with minutes -1.
REQ-015 RUN: when a decrement produces 00:00, the state SHALL become EXPIRED on that same clock edge.
REQ-016 RUN: start press -> PAUSE; set presses ignored.
REQ-017 PAUSE behaviour:
- prescaler and time frozen.
- start press -> RUN, resuming from the held prescaler value.
- minute press -> IDLE, time kept.
- second press ignored.
REQ-018 EXPIRED behaviour:
- done = 1.
- alarm toggles every TICKS_PER_SEC/2 cycles, starting at 1 on entry.
- any key press -> IDLE with time 00:00, done = 0, alarm = 0.
REQ-019 Simultaneous presses in one cycle: start has priority, then minute, then second; only the highest-priority press acts.
REQ-020 Display digits SHALL be driven combinationally from the registered BCD digits.

Reset
REQ-021 reset high SHALL immediately force:
- state IDLE, all digits 0, prescaler 0, alarm-phase counter 0;
- synchronizer and edge-detect flops to 1 (released key);
- done = 0, alarm = 0;
- HEX2..HEX5 showing "0".
REQ-022 Reset asserted mid-RUN or mid-EXPIRED SHALL abandon the operation; no press pulse may be generated on reset release.

Structure
REQ-023 State encoding, BLANK, and BCD limits (5, 9) SHALL live in a shared package (clock_pkg) used with the existing clock design.
REQ-024 SHALL instantiate the existing hex_7seg decoder four times; no other sub-module.
REQ-025 SHALL be 120-400 lines of RTL, with no latches and a single clock domain.

Verification (TICKS_PER_SEC = 10)
REQ-026 Reset, then 3 minute presses and 5 second presses -> HEX5..HEX2 display 0,3,0,5; state IDLE.
REQ-027 Set 00:02, press start -> 01 after 10 cycles, 00 after 20; done = 1 on the 00:00 edge; alarm toggles every 5 cycles.
REQ-028 Set 01:00, start, run 10 cycles -> 00:59; then start press -> PAUSE; wait 50 cycles -> still 00:59; start again -> 00:58 after the remaining prescaler cycles.
REQ-029 IDLE at 00:00, press start -> state stays IDLE, done = 0; 60 second presses -> display 00:00 (wrap).
REQ-030 Start and minute keys pressed in the same cycle at 00:10 in IDLE -> RUN entered, minutes unchanged.
REQ-031 Assert reset at 00:07 in RUN -> all outputs reach reset values without a clock edge; after release, no state change until a new press.
